// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: DEPTH x 32-bit words, WAIT_STATES wait cycles per OKAY data phase, byte/half/word writes.
// Optional macro AHB_SRAM_ERR_EN builds the two-cycle ERROR response for out-of-range, illegal-size and misaligned transfers.
module ahb_sram_slave #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic        H_clk,
  input  logic        H_reset,
  input  logic        H_sel,
  input  logic        H_ready_in,
  input  logic        H_write,
  input  logic [1:0]  H_trans,
  input  logic [2:0]  H_size,
  input  logic [31:0] H_addr,
  input  logic [31:0] H_wdata,
  output logic        H_ready,
  output logic [1:0]  H_resp,
  output logic [31:0] H_rdata
);

  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AHB_SRAM_ERR_EN
  localparam logic [1:0] RESP_ERROR = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_DATA = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } state_t;

  function automatic logic xfer_error(input logic [31:0] addr, input logic [2:0] size);
    logic range_err;
    logic size_err;
    logic align_err;
    range_err = ({2'b00, addr[31:2]} >= 32'(DEPTH));
    size_err  = (size > 3'b010);
    align_err = ((size == 3'b001) && addr[0]) ||
                ((size == 3'b010) && (addr[1:0] != 2'b00));
    return range_err || size_err || align_err;
  endfunction
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_DATA = 3'd2
  } state_t;
`endif

  // Illegal sizes fall through to a full-word write.
  function automatic logic [3:0] lane_enables(input logic [2:0] size, input logic [1:0] lo);
    logic [3:0] be;
    case (size)
      3'b000:  be = 4'b0001 << lo;
      3'b001:  be = lo[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  state_t        state_r, state_nxt_s;
  logic [2:0]    cnt_r, cnt_nxt_s;
  logic [AW+1:0] addr_r;
  logic          write_r;
  logic [2:0]    size_r;
  logic          ready_r, ready_nxt_s;
  logic [1:0]    resp_r, resp_nxt_s;
  logic [31:0]   rdata_r, rdata_nxt_s;
  logic          accept_s, open_s, err_s, load_s, commit_s;
  logic [3:0]    wr_be_s;
  logic [AW-1:0] wr_word_s, rd_word_s;
  logic [31:0]   rd_raw_s, rd_fwd_s;
  logic [31:0]   mem_r [DEPTH];
  logic          unused_s;

  assign unused_s = ^{H_trans[0], H_addr[31:AW+2]};

  assign accept_s = H_sel & H_ready_in & H_trans[1];
`ifdef AHB_SRAM_ERR_EN
  assign open_s = (state_r == S_IDLE) | (state_r == S_DATA) | (state_r == S_ERR2);
  assign err_s  = xfer_error(H_addr, H_size);
`else
  assign open_s = (state_r == S_IDLE) | (state_r == S_DATA);
  assign err_s  = 1'b0;
`endif

  assign commit_s  = (state_r == S_DATA) & write_r & ~H_reset;
  assign wr_be_s   = lane_enables(size_r, addr_r[1:0]);
  assign wr_word_s = addr_r[AW+1:2];
  assign rd_word_s = (state_r == S_WAIT) ? addr_r[AW+1:2] : H_addr[AW+1:2];
  assign rd_raw_s  = mem_r[rd_word_s];

  // Merge the write committing on this edge so a back-to-back read sees the new bytes.
  always_comb begin
    rd_fwd_s = rd_raw_s;
    for (int i = 0; i < 4; i++) begin
      if (commit_s && wr_be_s[i] && (wr_word_s == rd_word_s)) begin
        rd_fwd_s[8*i +: 8] = H_wdata[8*i +: 8];
      end else begin
        rd_fwd_s[8*i +: 8] = rd_raw_s[8*i +: 8];
      end
    end
  end

  // Next state and next registered bus response.
  always_comb begin
    state_nxt_s = S_IDLE;
    cnt_nxt_s   = cnt_r;
    ready_nxt_s = 1'b1;
    resp_nxt_s  = RESP_OKAY;
    rdata_nxt_s = 32'h0000_0000;
    load_s      = 1'b0;
    if (open_s && accept_s) begin
      load_s = 1'b1;
      if (err_s) begin
`ifdef AHB_SRAM_ERR_EN
        state_nxt_s = S_ERR1;
        ready_nxt_s = 1'b0;
        resp_nxt_s  = RESP_ERROR;
`else
        state_nxt_s = S_IDLE;
`endif
      end else if (WAIT_STATES == 0) begin
        state_nxt_s = S_DATA;
        rdata_nxt_s = H_write ? 32'h0000_0000 : rd_fwd_s;
      end else begin
        state_nxt_s = S_WAIT;
        cnt_nxt_s   = 3'(WAIT_STATES - 1);
        ready_nxt_s = 1'b0;
      end
    end else begin
      case (state_r)
        S_WAIT: begin
          if (cnt_r == 3'd0) begin
            state_nxt_s = S_DATA;
            rdata_nxt_s = write_r ? 32'h0000_0000 : rd_fwd_s;
          end else begin
            state_nxt_s = S_WAIT;
            cnt_nxt_s   = cnt_r - 3'd1;
            ready_nxt_s = 1'b0;
          end
        end
`ifdef AHB_SRAM_ERR_EN
        S_ERR1: begin
          state_nxt_s = S_ERR2;
          resp_nxt_s  = RESP_ERROR;
        end
`endif
        default: state_nxt_s = S_IDLE;
      endcase
    end
  end

  // State, captured address phase and registered bus response.
  always_ff @(posedge H_clk) begin
    if (H_reset) begin
      state_r <= S_IDLE;
      cnt_r   <= 3'd0;
      addr_r  <= {(AW+2){1'b0}};
      write_r <= 1'b0;
      size_r  <= 3'b000;
      ready_r <= 1'b1;
      resp_r  <= RESP_OKAY;
      rdata_r <= 32'h0000_0000;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      ready_r <= ready_nxt_s;
      resp_r  <= resp_nxt_s;
      rdata_r <= rdata_nxt_s;
      if (load_s) begin
        addr_r  <= H_addr[AW+1:0];
        write_r <= H_write;
        size_r  <= H_size;
      end
    end
  end

  // Byte-lane write port; the array itself is never reset.
  always_ff @(posedge H_clk) begin
    for (int i = 0; i < 4; i++) begin
      if (commit_s && wr_be_s[i]) begin
        mem_r[wr_word_s][8*i +: 8] <= H_wdata[8*i +: 8];
      end
    end
  end

  assign H_ready = ready_r;
  assign H_rdata = rdata_r;
`ifdef AHB_SRAM_ERR_EN
  assign H_resp  = resp_r;
`else
  assign H_resp  = RESP_OKAY;
`endif

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: a 0-wait and a 2-wait instance behind one pipelined bus master,
// with expected data-phase responses queued at address-phase time and checked when H_ready rises.
module tb_ahb_sram_slave;

  localparam logic [1:0] OK = 2'b00;
  localparam logic [1:0] ER = 2'b01;
  localparam logic [2:0] SZ_B = 3'b000;
  localparam logic [2:0] SZ_H = 3'b001;
  localparam logic [2:0] SZ_W = 3'b010;

  typedef struct {
    string       name;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          nlow;
  } txn_t;

  logic        H_clk = 1'b0;
  logic        H_reset, H_sel, H_write, force_nrdy, dsel;
  logic [1:0]  H_trans;
  logic [2:0]  H_size;
  logic [31:0] H_addr, H_wdata;
  logic        rdy0, rdy1, sel0, sel1, rin0, rin1, rdy_m;
  logic [1:0]  rsp0, rsp1, rsp_m;
  logic [31:0] rd0, rd1, rd_m;

  txn_t cmd_q[$];
  txn_t exp_q[$];
  int checks = 0;
  int errors = 0;

  always #5 H_clk = ~H_clk;

  assign sel0  = H_sel & (dsel == 1'b0);
  assign sel1  = H_sel & (dsel == 1'b1);
  assign rin0  = force_nrdy ? 1'b0 : rdy0;
  assign rin1  = force_nrdy ? 1'b0 : rdy1;
  assign rdy_m = dsel ? rdy1 : rdy0;
  assign rsp_m = dsel ? rsp1 : rsp0;
  assign rd_m  = dsel ? rd1 : rd0;

  ahb_sram_slave #(.DEPTH(1024), .WAIT_STATES(0)) u_ws0 (
    .H_clk(H_clk), .H_reset(H_reset), .H_sel(sel0), .H_ready_in(rin0), .H_write(H_write),
    .H_trans(H_trans), .H_size(H_size), .H_addr(H_addr), .H_wdata(H_wdata),
    .H_ready(rdy0), .H_resp(rsp0), .H_rdata(rd0));

  ahb_sram_slave #(.DEPTH(1024), .WAIT_STATES(2)) u_ws2 (
    .H_clk(H_clk), .H_reset(H_reset), .H_sel(sel1), .H_ready_in(rin1), .H_write(H_write),
    .H_trans(H_trans), .H_size(H_size), .H_addr(H_addr), .H_wdata(H_wdata),
    .H_ready(rdy1), .H_resp(rsp1), .H_rdata(rd1));

  task automatic add(input string n, input logic wr, input logic [2:0] sz, input logic [31:0] a,
                     input logic [31:0] wd, input logic [1:0] rsp, input logic [31:0] rd, input int nlow);
    txn_t t;
    t.name = n; t.wr = wr; t.size = sz; t.addr = a; t.wdata = wd;
    t.resp = rsp; t.rdata = rd; t.nlow = nlow;
    cmd_q.push_back(t);
  endtask

  // Pipelined master: address phase of the next command overlaps the data phase of the previous.
  task automatic run_cmds();
    txn_t c, e;
    logic [31:0] pend_wd;
    bit pend, have;
    int low, budget;
    pend = 1'b0; pend_wd = 32'h0; low = 0;
    while (cmd_q.size() > 0 || pend) begin
      have = (cmd_q.size() > 0);
      if (have) begin
        c = cmd_q.pop_front();
        H_sel = 1'b1; H_trans = 2'b10; H_write = c.wr; H_size = c.size; H_addr = c.addr;
        exp_q.push_back(c);
      end else begin
        H_sel = 1'b0; H_trans = 2'b00; H_write = 1'b0; H_size = SZ_W; H_addr = 32'h0;
      end
      H_wdata = pend ? pend_wd : 32'h0;
      budget = 0;
      @(negedge H_clk);
      while (rdy_m !== 1'b1) begin
        if (pend) begin
          e = exp_q[0];
          low++;
          checks++;
          if (rsp_m !== e.resp) begin
            errors++;
            $display("FAIL %s wait-cycle resp: got %0h expected %0h", e.name, rsp_m, e.resp);
          end
        end
        budget++;
        if (budget > 16) begin
          errors++;
          $display("FAIL bus timeout: H_ready stayed low for %0d cycles", budget);
          $display("Simulation finished: %0d checks, %0d errors", checks, errors);
          $fatal(1, "bus hung");
        end
        @(negedge H_clk);
      end
      if (pend) begin
        e = exp_q.pop_front();
        checks += 3;
        if (rsp_m !== e.resp) begin
          errors++;
          $display("FAIL %s resp: got %0h expected %0h", e.name, rsp_m, e.resp);
        end
        if (rd_m !== e.rdata) begin
          errors++;
          $display("FAIL %s rdata: got %08h expected %08h", e.name, rd_m, e.rdata);
        end
        if (low != e.nlow) begin
          errors++;
          $display("FAIL %s ready-low cycles: got %0d expected %0d", e.name, low, e.nlow);
        end
      end
      low = 0;
      @(posedge H_clk); #1;
      pend = have;
      pend_wd = have ? c.wdata : 32'h0;
    end
    H_sel = 1'b0; H_trans = 2'b00; H_wdata = 32'h0;
  endtask

  task automatic test_reset();
    H_reset = 1'b1; H_sel = 1'b0; H_write = 1'b0; H_trans = 2'b00; H_size = SZ_W;
    H_addr = 32'h0; H_wdata = 32'h0; force_nrdy = 1'b0; dsel = 1'b0;
    repeat (3) @(posedge H_clk);
    #1;
    checks += 6;
    if (rdy0 !== 1'b1) begin errors++; $display("FAIL reset ready0: got %0b expected 1", rdy0); end
    if (rsp0 !== OK) begin errors++; $display("FAIL reset resp0: got %0h expected 0", rsp0); end
    if (rd0 !== 32'h0) begin errors++; $display("FAIL reset rdata0: got %08h expected 0", rd0); end
    if (rdy1 !== 1'b1) begin errors++; $display("FAIL reset ready1: got %0b expected 1", rdy1); end
    if (rsp1 !== OK) begin errors++; $display("FAIL reset resp1: got %0h expected 0", rsp1); end
    if (rd1 !== 32'h0) begin errors++; $display("FAIL reset rdata1: got %08h expected 0", rd1); end
    H_reset = 1'b0;
    @(posedge H_clk); #1;
  endtask

  task automatic test_rw_ws0();
    dsel = 1'b0;
    add("ws0_wr10", 1'b1, SZ_W, 32'h10, 32'hDEAD_BEEF, OK, 32'h0, 0);
    add("ws0_rd10", 1'b0, SZ_W, 32'h10, 32'h0, OK, 32'hDEAD_BEEF, 0);
    run_cmds();
  endtask

  task automatic test_wait_ws2();
    dsel = 1'b1;
    add("ws2_wr10", 1'b1, SZ_W, 32'h10, 32'hDEAD_BEEF, OK, 32'h0, 2);
    add("ws2_rd10", 1'b0, SZ_W, 32'h10, 32'h0, OK, 32'hDEAD_BEEF, 2);
    run_cmds();
  endtask

  task automatic test_byte_half();
    dsel = 1'b0;
    add("byte12", 1'b1, SZ_B, 32'h12, 32'h00AA_0000, OK, 32'h0, 0);
    add("half10", 1'b1, SZ_H, 32'h10, 32'h0000_1234, OK, 32'h0, 0);
    add("rd10_merged", 1'b0, SZ_W, 32'h10, 32'h0, OK, 32'hDEAA_1234, 0);
    add("wr14_clear", 1'b1, SZ_W, 32'h14, 32'h0000_0000, OK, 32'h0, 0);
    add("byte15", 1'b1, SZ_B, 32'h15, 32'h0000_5500, OK, 32'h0, 0);
    add("half16", 1'b1, SZ_H, 32'h16, 32'hA5C3_0000, OK, 32'h0, 0);
    add("rd14_merged", 1'b0, SZ_B, 32'h14, 32'h0, OK, 32'hA5C3_5500, 0);
    run_cmds();
  endtask

  task automatic test_error();
    dsel = 1'b0;
    add("wr00", 1'b1, SZ_W, 32'h00, 32'h1122_3344, OK, 32'h0, 0);
    add("wr04", 1'b1, SZ_W, 32'h04, 32'h5566_7788, OK, 32'h0, 0);
`ifdef AHB_SRAM_ERR_EN
    add("rd1000_range", 1'b0, SZ_W, 32'h1000, 32'h0, ER, 32'h0, 1);
    add("wr02_misalign", 1'b1, SZ_W, 32'h02, 32'hFFFF_FFFF, ER, 32'h0, 1);
    add("wr04_badsize", 1'b1, 3'b011, 32'h04, 32'h0BAD_F00D, ER, 32'h0, 1);
    add("rd00_after_err", 1'b0, SZ_W, 32'h00, 32'h0, OK, 32'h1122_3344, 0);
    add("rd04_after_err", 1'b0, SZ_W, 32'h04, 32'h0, OK, 32'h5566_7788, 0);
`else
    add("rd1000_wrap", 1'b0, SZ_W, 32'h1000, 32'h0, OK, 32'h1122_3344, 0);
    add("wr02_lowbits", 1'b1, SZ_W, 32'h02, 32'hFFFF_FFFF, OK, 32'h0, 0);
    add("wr04_asword", 1'b1, 3'b011, 32'h04, 32'h0BAD_F00D, OK, 32'h0, 0);
    add("rd00_after", 1'b0, SZ_W, 32'h00, 32'h0, OK, 32'hFFFF_FFFF, 0);
    add("rd04_after", 1'b0, SZ_W, 32'h04, 32'h0, OK, 32'h0BAD_F00D, 0);
`endif
    run_cmds();
  endtask

  task automatic test_idle_busy();
    dsel = 1'b0;
    add("wr30", 1'b1, SZ_W, 32'h30, 32'hCAFE_F00D, OK, 32'h0, 0);
    run_cmds();
    for (int k = 0; k < 6; k++) begin
      H_sel = 1'b1; H_write = 1'b1; H_addr = 32'h30; H_size = SZ_W; H_wdata = 32'hFFFF_FFFF;
      H_trans = (k < 2) ? 2'b01 : ((k < 4) ? 2'b00 : 2'b10);
      force_nrdy = (k >= 4);
      @(posedge H_clk); #1;
      checks += 3;
      if (rdy0 !== 1'b1) begin errors++; $display("FAIL noaccept%0d ready: got %0b expected 1", k, rdy0); end
      if (rsp0 !== OK) begin errors++; $display("FAIL noaccept%0d resp: got %0h expected 0", k, rsp0); end
      if (rd0 !== 32'h0) begin errors++; $display("FAIL noaccept%0d rdata: got %08h expected 0", k, rd0); end
    end
    H_sel = 1'b0; H_trans = 2'b00; H_write = 1'b0; H_wdata = 32'h0; force_nrdy = 1'b0;
    add("rd30_unchanged", 1'b0, SZ_W, 32'h30, 32'h0, OK, 32'hCAFE_F00D, 0);
    run_cmds();
  endtask

  task automatic test_reset_wait();
    dsel = 1'b1;
    add("ws2_wr20", 1'b1, SZ_W, 32'h20, 32'h0102_0304, OK, 32'h0, 2);
    run_cmds();
    H_sel = 1'b1; H_trans = 2'b10; H_write = 1'b1; H_size = SZ_W; H_addr = 32'h20;
    @(posedge H_clk); #1;
    checks++;
    if (rdy1 !== 1'b0) begin errors++; $display("FAIL abort_wait ready: got %0b expected 0", rdy1); end
    H_sel = 1'b0; H_trans = 2'b00; H_write = 1'b0; H_wdata = 32'hFFFF_FFFF; H_reset = 1'b1;
    @(posedge H_clk); #1;
    checks += 3;
    if (rdy1 !== 1'b1) begin errors++; $display("FAIL abort_reset ready: got %0b expected 1", rdy1); end
    if (rsp1 !== OK) begin errors++; $display("FAIL abort_reset resp: got %0h expected 0", rsp1); end
    if (rd1 !== 32'h0) begin errors++; $display("FAIL abort_reset rdata: got %08h expected 0", rd1); end
    H_reset = 1'b0; H_wdata = 32'h0;
    @(posedge H_clk); #1;
    add("ws2_rd20_kept", 1'b0, SZ_W, 32'h20, 32'h0, OK, 32'h0102_0304, 2);
    run_cmds();
  endtask

  initial begin
    test_reset();
    test_rw_ws0();
    test_wait_ws2();
    test_byte_half();
    test_error();
    test_idle_busy();
    test_reset_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_sram_slave.md
Name: ahb_sram_slave

Overview:
Parametrised AHB-Lite SRAM slave, the successor to the fixed 1024x32 slave wrapper. It adds configurable depth and programmable wait states, and supports byte, half-word and word writes via H_size. It also qualifies transfers with H_ready_in, generates the two-cycle ERROR response, and pipelines address and data phases correctly. It sits on the system AHB bus as an on-chip data memory.

Parameters:
DEPTH, 1024, number of 32-bit words; power of 2, minimum 4.
WAIT_STATES, 0, wait cycles inserted at the start of each OKAY data phase; range 0-7.
AW, $clog2(DEPTH), word-address width; derived, not overridden.

Ports:
H_clk  input  1  bus clock, rising edge.
H_reset  input  1  synchronous reset, active-high.
H_sel  input  1  slave select.
H_ready_in  input  1  bus HREADY; previous transfer complete.
H_write  input  1  1 = write, 0 = read.
H_trans  input  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
H_size  input  3  000 byte, 001 half, 010 word; others illegal.
H_addr  input  32  byte address.
H_wdata  input  32  write data, valid for the whole data phase.
H_ready  output  1  transfer-complete response.
H_resp  output  2  OKAY=00, ERROR=01.
H_rdata  output  32  read data.

Behaviour:
- Reset: synchronous and active-high; the reset value of every output and register is given in the "Reset" bullet below.
- Accept: a transfer is accepted on a rising edge where H_sel & H_ready_in & H_trans[1] are all 1. On accept, register addr, write and size, and set an error flag if any of these hold:
  - word address H_addr[31:2] >= DEPTH;
  - H_size > 010;
  - half-word with H_addr[0] = 1;
  - word with H_addr[1:0] != 00.
- IDLE/BUSY or unselected: no access; next state S_IDLE; zero-wait OKAY.
- States and outputs:
  - S_IDLE: H_ready 1, H_resp OKAY, H_rdata 0.
  - S_WAIT: H_ready 0, H_resp OKAY, H_rdata 0.
  - S_DATA: H_ready 1, H_resp OKAY, H_rdata = mem[addr_q] for reads, 0 for writes.
  - S_ERR1: H_ready 0, H_resp ERROR.
  - S_ERR2: H_ready 1, H_resp ERROR, H_rdata 0.
- Transitions on accept, from S_IDLE, S_DATA or S_ERR2:
  - error flag set -> S_ERR1;
  - else WAIT_STATES = 0 -> S_DATA;
  - else -> S_WAIT, with the counter loaded to WAIT_STATES-1.
- S_WAIT: decrement the counter; leave for S_DATA when the counter is 0. This gives exactly WAIT_STATES low-H_ready cycles.
- S_ERR1 always goes to S_ERR2. ERROR is never preceded by wait states.
- From S_DATA or S_ERR2 with no accept: go to S_IDLE.
- Back-to-back: a new address phase is accepted in the final (H_ready = 1) cycle of the current data phase. Accepts are ignored while H_ready_in = 0.
- Write commit: on the S_DATA rising edge, only the selected lanes are written, little-endian:
  - byte: lane H_addr[1:0], data taken from the same lane of H_wdata;
  - half: lanes {addr[1],1} and {addr[1],0};
  - word: all 4 lanes.
- Read: always returns the full word regardless of size. Read latency is 1 + WAIT_STATES cycles after accept.
- Read-after-write to the same address, back-to-back: the read data phase returns the newly written value. The write commits on the edge that starts the read data phase.
- Errored writes do not modify memory.
- Memory array is not reset; contents are undefined until written.
- Reset: H_reset = 1 at any edge forces S_IDLE and clears the counter, addr_q and error flag. Any pending write is discarded. While in reset, outputs are H_ready 1, H_resp OKAY, H_rdata 0.

Optional Feature:
AHB_SRAM_ERR_EN
- Defined: error detection and the S_ERR1/S_ERR2 response are as above.
- Undefined: no ERROR is ever generated and S_ERR1/S_ERR2 are not built; H_resp is tied to OKAY.
  - Out-of-range word addresses wrap modulo DEPTH (use the low AW bits).
  - Illegal H_size is treated as word.
  - Misaligned accesses ignore the low address bits below the access size.

Test Plan:
1. WAIT_STATES=0: write word 0xDEADBEEF to 0x10, then read 0x10 back-to-back -> write phase 1 cycle, read H_ready=1 in the next cycle with H_rdata=0xDEADBEEF, OKAY.
2. WAIT_STATES=2: read 0x10 -> H_ready=0 for 2 cycles, then 1 with 0xDEADBEEF.
3. Byte write 0xAA at 0x12 (H_wdata 0x00AA0000), half write 0x1234 at 0x10 (H_wdata 0x00001234), read 0x10 -> 0xDEAA1234.
4. ERR_EN defined, DEPTH=1024: read 0x1000, then word write at 0x02 -> each gives ERROR for 2 cycles (H_ready 0 then 1); a following read of 0x00 shows memory unchanged.
5. H_trans BUSY or IDLE with H_sel=1, and NONSEQ with H_ready_in=0 -> no state change, H_ready=1, OKAY, memory unchanged.
6. Assert H_reset during S_WAIT of a write to 0x20 -> next cycle S_IDLE, H_ready=1, OKAY; a later read of 0x20 returns the value it held before the aborted write.
